// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display.
// Segment constants are active-high, bit order {g,f,e,d,c,b,a}.
package display_pkg;

  typedef enum logic [1:0] {
    SLOT_UNIDADE = 2'd0,
    SLOT_DEZENA  = 2'd1,
    SLOT_SINAL   = 2'd2
  } slot_t;

  localparam logic [6:0] SEG_0       = 7'b0111111;
  localparam logic [6:0] SEG_1       = 7'b0000110;
  localparam logic [6:0] SEG_2       = 7'b1011011;
  localparam logic [6:0] SEG_3       = 7'b1001111;
  localparam logic [6:0] SEG_4       = 7'b1100110;
  localparam logic [6:0] SEG_5       = 7'b1101101;
  localparam logic [6:0] SEG_6       = 7'b1111101;
  localparam logic [6:0] SEG_7       = 7'b0000111;
  localparam logic [6:0] SEG_8       = 7'b1111111;
  localparam logic [6:0] SEG_9       = 7'b1101111;
  localparam logic [6:0] SEG_TRACO   = 7'b1000000;
  localparam logic [6:0] SEG_APAGADO = 7'b0000000;

endpackage

// File: rtl/decodificador_7seg.sv
// BCD digit to active-high 7-segment pattern. Non-decimal codes show a dash.
module decodificador_7seg
  import display_pkg::*;
(
  input  logic [3:0] digito,
  output logic [6:0] padrao
);

  // Combinational lookup of the segment pattern
  always_comb begin
    padrao = SEG_TRACO;
    case (digito)
      4'd0: padrao = SEG_0;
      4'd1: padrao = SEG_1;
      4'd2: padrao = SEG_2;
      4'd3: padrao = SEG_3;
      4'd4: padrao = SEG_4;
      4'd5: padrao = SEG_5;
      4'd6: padrao = SEG_6;
      4'd7: padrao = SEG_7;
      4'd8: padrao = SEG_8;
      4'd9: padrao = SEG_9;
      default: padrao = SEG_TRACO;
    endcase
  end

endmodule

// File: rtl/display_multiplexado.sv
// Three-digit (sign, tens, units) time-multiplexed 7-segment driver.
// New values are buffered and committed only at a frame boundary so that a
// frame never mixes old and new digits.
// Optional: DISPLAY_BLANK_ZERO_EN blanks the tens digit when it is zero.
module display_multiplexado
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          ATIVO_BAIXO = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       carregar,
  input  logic       sinal,
  input  logic [3:0] dezena,
  input  logic [3:0] unidade,
  output logic       atualizado,
  output logic       quadro,
  output logic [2:0] anodos,
  output logic [6:0] segmentos
);

  localparam int unsigned    CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  CONT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [2:0]     AN_OFF   = {3{ATIVO_BAIXO}};
  localparam logic [6:0]     SEG_OFF  = {7{ATIVO_BAIXO}};

  logic [CW-1:0] cont;
  logic          fim_slot;
  logic          fronteira;
  slot_t         slot, slot_next;

  logic          pend;
  logic          pend_sinal, shown_sinal;
  logic [3:0]    pend_dezena, shown_dezena;
  logic [3:0]    pend_unidade, shown_unidade;

  logic [3:0]    digito_sel;
  logic [6:0]    padrao_dig;
  logic [6:0]    seg_ah;
  logic [2:0]    an_ah;

  assign fim_slot  = (cont == CONT_MAX);
  assign fronteira = fim_slot && (slot == SLOT_SINAL);

  // Slot dwell counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cont <= '0;
    else if (fim_slot) cont <= '0;
    else cont <= cont + 1'b1;
  end

  // Slot state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) slot <= SLOT_UNIDADE;
    else slot <= slot_next;
  end

  // Slot sequencing: units -> tens -> sign at each terminal count
  always_comb begin
    slot_next = slot;
    if (fim_slot) begin
      case (slot)
        SLOT_UNIDADE: slot_next = SLOT_DEZENA;
        SLOT_DEZENA:  slot_next = SLOT_SINAL;
        SLOT_SINAL:   slot_next = SLOT_UNIDADE;
        default:      slot_next = SLOT_UNIDADE;
      endcase
    end
  end

  // Pending buffer and shown registers; a commit coinciding with a load
  // takes the old pending value and leaves the new one pending
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend          <= 1'b0;
      pend_sinal    <= 1'b0;
      pend_dezena   <= '0;
      pend_unidade  <= '0;
      shown_sinal   <= 1'b0;
      shown_dezena  <= '0;
      shown_unidade <= '0;
    end else begin
      if (fronteira && pend) begin
        shown_sinal   <= pend_sinal;
        shown_dezena  <= pend_dezena;
        shown_unidade <= pend_unidade;
        pend          <= 1'b0;
      end
      if (carregar) begin
        pend_sinal   <= sinal;
        pend_dezena  <= dezena;
        pend_unidade <= unidade;
        pend         <= 1'b1;
      end
    end
  end

  assign digito_sel = (slot == SLOT_UNIDADE) ? shown_unidade : shown_dezena;

  decodificador_7seg u_decod (
    .digito (digito_sel),
    .padrao (padrao_dig)
  );

  // Active-high pattern and digit enable for the current slot
  always_comb begin
    seg_ah = SEG_APAGADO;
    an_ah  = 3'b000;
    case (slot)
      SLOT_UNIDADE: begin
        an_ah  = 3'b001;
        seg_ah = padrao_dig;
      end
      SLOT_DEZENA: begin
        an_ah  = 3'b010;
`ifdef DISPLAY_BLANK_ZERO_EN
        seg_ah = (shown_dezena == 4'd0) ? SEG_APAGADO : padrao_dig;
`else
        seg_ah = padrao_dig;
`endif
      end
      SLOT_SINAL: begin
        an_ah  = 3'b100;
        seg_ah = shown_sinal ? SEG_TRACO : SEG_APAGADO;
      end
      default: begin
        an_ah  = 3'b000;
        seg_ah = SEG_APAGADO;
      end
    endcase
  end

  // Registered outputs with polarity applied
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      anodos     <= AN_OFF;
      segmentos  <= SEG_OFF;
      quadro     <= 1'b0;
      atualizado <= 1'b0;
    end else begin
      anodos     <= an_ah ^ AN_OFF;
      segmentos  <= seg_ah ^ SEG_OFF;
      quadro     <= fronteira;
      atualizado <= fronteira && pend;
    end
  end

endmodule

// File: tb/tb_display_multiplexado.sv
// Self-checking bench for display_multiplexado (REFRESH_DIV=4, active-high).
module tb_display_multiplexado;

  localparam int unsigned RD    = 4;
  localparam int unsigned FRAME = 3 * RD;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       carregar = 1'b0;
  logic       sinal = 1'b0;
  logic [3:0] dezena = '0;
  logic [3:0] unidade = '0;
  logic       atualizado;
  logic       quadro;
  logic [2:0] anodos;
  logic [6:0] segmentos;

  display_multiplexado #(
    .REFRESH_DIV (RD),
    .ATIVO_BAIXO (1'b0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .carregar   (carregar),
    .sinal      (sinal),
    .dezena     (dezena),
    .unidade    (unidade),
    .atualizado (atualizado),
    .quadro     (quadro),
    .anodos     (anodos),
    .segmentos  (segmentos)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: edge count since reset release plus shown/pending values
  int unsigned n;
  logic        m_pend;
  logic [8:0]  m_pending;
  logic [8:0]  m_shown;
  logic [6:0]  digit_tab [16];

  typedef struct {
    logic       s;
    logic [3:0] d;
    logic [3:0] u;
    logic [6:0] e_sign;
    logic [6:0] e_tens;
    logic [6:0] e_units;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got %h expected %h", name, n, act, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int unsigned s, input logic [8:0] sh);
    logic [3:0] d;
    logic [3:0] u;
    d = sh[7:4];
    u = sh[3:0];
    if (s == 0) return digit_tab[u];
    if (s == 1) begin
`ifdef DISPLAY_BLANK_ZERO_EN
      if (d == 4'd0) return 7'h00;
`endif
      return digit_tab[d];
    end
    return sh[8] ? 7'h40 : 7'h00;
  endfunction

  task automatic model_reset();
    n = 0;
    m_pend = 1'b0;
    m_pending = '0;
    m_shown = '0;
  endtask

  task automatic step(input logic c, input logic s, input logic [3:0] d, input logic [3:0] u);
    int unsigned sl;
    logic        bnd;
    logic [2:0]  e_an;
    logic [6:0]  e_sg;
    logic        e_at;
    carregar = c;
    sinal    = s;
    dezena   = d;
    unidade  = u;
    sl   = (n / RD) % 3;
    bnd  = ((n % FRAME) == FRAME - 1);
    e_an = 3'(1 << sl);
    e_sg = exp_seg(sl, m_shown);
    e_at = bnd && m_pend;
    if (e_at) begin
      m_shown = m_pending;
      m_pend  = 1'b0;
    end
    if (c) begin
      m_pending = {s, d, u};
      m_pend    = 1'b1;
    end
    @(posedge clock);
    #1;
    check("cycle", {4'b0, anodos, segmentos, quadro, atualizado},
                   {4'b0, e_an, e_sg, bnd, e_at});
    n++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 4'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int   q_count;
    int   at_count;
    logic got;
    logic [6:0] seg_hist [24];
    logic       at_hist  [24];

    digit_tab[0] = 7'h3F; digit_tab[1] = 7'h06; digit_tab[2] = 7'h5B; digit_tab[3] = 7'h4F;
    digit_tab[4] = 7'h66; digit_tab[5] = 7'h6D; digit_tab[6] = 7'h7D; digit_tab[7] = 7'h07;
    digit_tab[8] = 7'h7F; digit_tab[9] = 7'h6F;
    for (int i = 10; i < 16; i++) digit_tab[i] = 7'h40;

    vecs[0] = '{1'b0, 4'd4, 4'd2, 7'h00, 7'h66, 7'h5B};
    vecs[1] = '{1'b1, 4'd9, 4'd9, 7'h40, 7'h6F, 7'h6F};
    vecs[2] = '{1'b0, 4'hC, 4'hF, 7'h00, 7'h40, 7'h40};
`ifdef DISPLAY_BLANK_ZERO_EN
    vecs[3] = '{1'b0, 4'd0, 4'd7, 7'h00, 7'h00, 7'h07};
`else
    vecs[3] = '{1'b0, 4'd0, 4'd7, 7'h00, 7'h3F, 7'h07};
`endif
    vecs[4] = '{1'b1, 4'd3, 4'd8, 7'h40, 7'h4F, 7'h7F};
    vecs[5] = '{1'b0, 4'd5, 4'd6, 7'h00, 7'h6D, 7'h7D};
    vecs[6] = '{1'b1, 4'd1, 4'd0, 7'h40, 7'h06, 7'h3F};

    // Reset state
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check("reset_outputs", {4'b0, anodos, segmentos, quadro, atualizado}, 16'h0000);
    reset = 1'b1;

    // Scan sequence: first pattern, slot advance, quadro period
    idle();
    check("first_anodos", {13'b0, anodos}, 16'h0001);
    check("first_seg", {9'b0, segmentos}, 16'h003F);
    q_count = 0;
    for (int i = 0; i < 23; i++) begin
      idle();
      if (quadro) q_count++;
    end
    check("quadro_count", 16'(q_count), 16'd2);

    // Table-driven: load, wait for commit, inspect the following frame
    for (int v = 0; v < 7; v++) begin
      step(1'b1, vecs[v].s, vecs[v].d, vecs[v].u);
      got = 1'b0;
      for (int i = 0; i < 30; i++) begin
        idle();
        if (atualizado) begin
          got = 1'b1;
          break;
        end
      end
      check("wait_commit", {15'b0, got}, 16'h0001);
      for (int k = 0; k < 12; k++) begin
        idle();
        if (k == 0) check("vec_units", {9'b0, segmentos}, {9'b0, vecs[v].e_units});
        if (k == 4) check("vec_tens",  {9'b0, segmentos}, {9'b0, vecs[v].e_tens});
        if (k == 8) check("vec_sign",  {9'b0, segmentos}, {9'b0, vecs[v].e_sign});
      end
    end

    // Load on the boundary cycle while another value is pending
    while ((n % FRAME) != 5) idle();
    step(1'b1, 1'b0, 4'd1, 4'd1);
    while ((n % FRAME) != FRAME - 1) idle();
    step(1'b1, 1'b1, 4'd9, 4'd9);
    check("bnd_commit_pulse", {15'b0, atualizado}, 16'h0001);
    for (int k = 0; k < 24; k++) begin
      idle();
      seg_hist[k] = segmentos;
      at_hist[k]  = atualizado;
    end
    check("bnd_units_11", {9'b0, seg_hist[0]}, 16'h0006);
    check("bnd_tens_11",  {9'b0, seg_hist[4]}, 16'h0006);
    check("bnd_sign_11",  {9'b0, seg_hist[8]}, 16'h0000);
    check("bnd_second_pulse", {15'b0, at_hist[11]}, 16'h0001);
    check("bnd_units_99", {9'b0, seg_hist[12]}, 16'h006F);
    check("bnd_tens_99",  {9'b0, seg_hist[16]}, 16'h006F);
    check("bnd_sign_neg", {9'b0, seg_hist[20]}, 16'h0040);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 6) == 0, 1'($urandom), 4'($urandom), 4'($urandom));
    end

    // Reset mid-slot with a pending load
    while ((n % FRAME) != 2) idle();
    step(1'b1, 1'b1, 4'd8, 4'd8);
    idle();
    reset = 1'b0;
    #1;
    check("midreset_outputs", {4'b0, anodos, segmentos, quadro, atualizado}, 16'h0000);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    at_count = 0;
    for (int i = 0; i < 30; i++) begin
      idle();
      if (atualizado) at_count++;
      if (i == 0) check("midreset_first_seg", {9'b0, segmentos}, 16'h003F);
    end
    check("midreset_no_pulse", 16'(at_count), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
